// File: rtl/sfifo_ctl.sv
// sfifo_ctl: single-clock FIFO with show-ahead/registered output, almost flags and sticky error flags.
module sfifo_ctl #(
  parameter int BW                = 8,
  parameter int LGFLEN            = 4,
  parameter int OPT_REGOUT        = 0,
  parameter int OPT_WRITE_ON_FULL = 0,
  parameter int AF_LEVEL          = (1 << LGFLEN) - 1,
  parameter int AE_LEVEL          = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  output logic              o_full,
  output logic              o_afull,
  output logic [LGFLEN:0]   o_fill,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_valid,
  output logic              o_empty,
  output logic              o_aempty,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam logic [LGFLEN:0] DEPTH = (LGFLEN+1)'(1 << LGFLEN);
  localparam logic [LGFLEN:0] AF_L  = (LGFLEN+1)'(AF_LEVEL);
  localparam logic [LGFLEN:0] AE_L  = (LGFLEN+1)'(AE_LEVEL);
  localparam logic [LGFLEN:0] ONE   = (LGFLEN+1)'(1);
  logic [BW-1:0]   mem [1 << LGFLEN];
  logic [LGFLEN:0] wr_addr, rd_addr;
  logic            w_wr, w_rd;
  // The extra pointer bit distinguishes full from empty; fill wraps modulo 2^(LGFLEN+1).
  assign o_fill   = wr_addr - rd_addr;
  assign o_full   = o_fill == DEPTH;
  assign o_empty  = o_fill == '0;
  assign o_afull  = o_fill >= AF_L;
  assign o_aempty = o_fill <= AE_L;
  assign w_rd     = i_rd && !o_empty;
  assign w_wr     = i_wr && (!o_full || (OPT_WRITE_ON_FULL != 0 && w_rd));
  always_ff @(posedge i_clk)
    if (w_wr) mem[wr_addr[LGFLEN-1:0]] <= i_data;
  always_ff @(posedge i_clk)
    if (i_reset) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (w_wr) wr_addr <= wr_addr + ONE;
      if (w_rd) rd_addr <= rd_addr + ONE;
      if (i_wr && !w_wr) o_overflow <= 1'b1;
      if (i_rd && o_empty) o_underflow <= 1'b1;
    end
  generate
    if (OPT_REGOUT != 0) begin : g_reg
      always_ff @(posedge i_clk)
        if (i_reset) begin
          o_valid <= 1'b0;
          o_data  <= '0;
        end else begin
          o_valid <= w_rd;
          if (w_rd) o_data <= mem[rd_addr[LGFLEN-1:0]];
        end
    end else begin : g_sa
      assign o_data  = mem[rd_addr[LGFLEN-1:0]];
      assign o_valid = !o_empty;
    end
  endgenerate
endmodule

// File: tb/tb_sfifo_ctl.sv
// tb_sfifo_ctl: two instances on shared stimulus (show-ahead + write-on-full, registered + no write-on-full).
module tb_sfifo_ctl;
  logic       clk = 1'b0;
  logic       rst, wr, rd;
  logic [7:0] din;
  logic       f0, af0, e0, ae0, v0, ov0, un0;
  logic       f1, af1, e1, ae1, v1, ov1, un1;
  logic [4:0] fl0, fl1;
  logic [7:0] d0, d1;
  int n_cmp = 0, n_err = 0;
  logic [7:0] q[$];
  logic       m_ov, m_un;
  always #5 clk = ~clk;
  sfifo_ctl #(.BW(8), .LGFLEN(4), .OPT_REGOUT(0), .OPT_WRITE_ON_FULL(1)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(din), .o_full(f0), .o_afull(af0),
    .o_fill(fl0), .i_rd(rd), .o_data(d0), .o_valid(v0), .o_empty(e0), .o_aempty(ae0),
    .o_overflow(ov0), .o_underflow(un0));
  sfifo_ctl #(.BW(8), .LGFLEN(4), .OPT_REGOUT(1), .OPT_WRITE_ON_FULL(0)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(din), .o_full(f1), .o_afull(af1),
    .o_fill(fl1), .i_rd(rd), .o_data(d1), .o_valid(v1), .o_empty(e1), .o_aempty(ae1),
    .o_overflow(ov1), .o_underflow(un1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r_s, input logic w, input logic r, input logic [7:0] d);
    rst = r_s; wr = w; rd = r; din = d;
    @(posedge clk);
    #1;
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask
  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask
  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
    do_reset();
    chk("rst fill", 32'(fl0), 0);
    chk("rst empty", 32'(e0), 1);
    chk("rst aempty", 32'(ae0), 1);
    chk("rst full", 32'(f0), 0);
    chk("rst afull", 32'(af0), 0);
    chk("rst valid1", 32'(v1), 0);
    chk("rst data1", 32'(d1), 0);
    chk("rst ovf", 32'({ov0, ov1}), 0);
    chk("rst unf", 32'({un0, un1}), 0);
    // basic write/read of three words
    step(1'b0, 1'b1, 1'b0, 8'h11);
    chk("t1 sa data", 32'(d0), 32'h11);
    chk("t1 fill1", 32'(fl0), 1);
    step(1'b0, 1'b1, 1'b0, 8'h22);
    step(1'b0, 1'b1, 1'b0, 8'h33);
    chk("t1 fill3", 32'(fl0), 3);
    chk("t1 aempty", 32'(ae0), 0);
    for (int i = 0; i < 3; i++) begin
      chk("t1 head0", 32'(d0), 32'h11 * (i + 1));
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("t1 rd1 data", 32'(d1), 32'h11 * (i + 1));
      chk("t1 rd1 valid", 32'(v1), 1);
      chk("t1 fill", 32'(fl0), 32'(2 - i));
    end
    chk("t1 empty", 32'(e0), 1);
    chk("t1 valid0", 32'(v0), 0);
    chk("t1 flags", 32'({ov0, un0, ov1, un1}), 0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t1 v1 drop", 32'(v1), 0);
    chk("t1 d1 hold", 32'(d1), 32'h33);
    // fill to depth, then one refused write
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
      if (i == 13) chk("t2 afull14", 32'(af0), 0);
      if (i == 14) begin
        chk("t2 afull15", 32'({af0, af1}), 3);
        chk("t2 full15", 32'(f0), 0);
      end
    end
    chk("t2 full", 32'({f0, f1}), 3);
    chk("t2 ovf pre", 32'({ov0, ov1}), 0);
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("t2 fill", 32'(fl0), 16);
    chk("t2 ovf", 32'({ov0, ov1}), 3);
    for (int i = 0; i < 16; i++) begin
      chk("t2 head0", 32'(d0), 32'(8'h40 + i));
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("t2 rd1", 32'(d1), 32'(8'h40 + i));
    end
    chk("t2 empty", 32'({e0, e1}), 3);
    chk("t2 ovf sticky", 32'({ov0, ov1}), 3);
    chk("t2 unf", 32'({un0, un1}), 0);
    // full with simultaneous write and read
    do_reset();
    chk("t3 ovf clr", 32'({ov0, ov1}), 0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    step(1'b0, 1'b1, 1'b1, 8'h99);
    chk("t3 wof fill", 32'(fl0), 16);
    chk("t3 wof full", 32'(f0), 1);
    chk("t3 wof ovf", 32'(ov0), 0);
    chk("t3 wof head", 32'(d0), 32'h61);
    chk("t3 nwof fill", 32'(fl1), 15);
    chk("t3 nwof ovf", 32'(ov1), 1);
    chk("t3 nwof data", 32'({v1, d1}), 32'h160);
    // empty with simultaneous write and read
    do_reset();
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    chk("t4 unf", 32'({un0, un1}), 3);
    chk("t4 fill", 32'({fl0, fl1}), 32'h21);
    chk("t4 sa data", 32'(d0), 32'hA5);
    chk("t4 v1", 32'(v1), 0);
    // registered-output single-cycle valid
    do_reset();
    step(1'b0, 1'b1, 1'b0, 8'h5A);
    chk("t5 v1 early", 32'(v1), 0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("t5 v1 rd", 32'({v1, d1}), 32'h15A);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("t5 v1 hold", 32'({v1, d1}), 32'h05A);
    // random traffic against a queue model for the show-ahead instance
    do_reset();
    q = {}; m_ov = 1'b0; m_un = 1'b0;
    for (int c = 0; c < 100; c++) begin
      logic w, r, ar, aw, rs;
      logic [7:0] d;
      w  = $urandom_range(0, 99) < 60;
      r  = $urandom_range(0, 99) < 50;
      d  = 8'($urandom);
      rs = (c == 60);
      ar = r && q.size() != 0;
      aw = w && (q.size() < 16 || ar);
      if (q.size() != 0) chk("rnd head", 32'(d0), 32'(q[0]));
      step(rs, w, r, d);
      if (rs) begin
        q = {}; m_ov = 1'b0; m_un = 1'b0;
        chk("rnd rst empty", 32'({e0, e1}), 3);
        chk("rnd rst fill", 32'({fl0, fl1}), 0);
        chk("rnd rst flags", 32'({ov0, un0, ov1, un1}), 0);
        chk("rnd rst v", 32'({v0, v1}), 0);
      end else begin
        if (ar) void'(q.pop_front());
        if (aw) q.push_back(d);
        if (w && !aw) m_ov = 1'b1;
        if (r && !ar) m_un = 1'b1;
        chk("rnd fill", 32'(fl0), 32'(q.size()));
        chk("rnd flags", 32'({ov0, un0}), 32'({m_ov, m_un}));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
